// File: rtl/sram_arbiter_if.sv
// Client and SRAM pad signal bundle for sram_arbiter; slave = arbiter side,
// master = display/renderer clients plus the SRAM pad model.
interface sram_arbiter_if;
  logic        disp_req;
  logic [19:0] disp_addr;
  logic [31:0] disp_rdata;
  logic        disp_ack;

  logic        rend_req;
  logic        rend_we;
  logic [19:0] rend_addr;
  logic [31:0] rend_wdata;
  logic [3:0]  rend_be;
  logic [31:0] rend_rdata;
  logic        rend_ack;

  logic [19:0] sram_addr;
  logic [31:0] sram_dout;
  logic        sram_dout_en;
  logic [31:0] sram_din;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  logic        busy;

  modport slave (
    input  disp_req, disp_addr,
    output disp_rdata, disp_ack,
    input  rend_req, rend_we, rend_addr, rend_wdata, rend_be,
    output rend_rdata, rend_ack,
    output sram_addr, sram_dout, sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
    input  sram_din,
    output busy
  );

  modport master (
    output disp_req, disp_addr,
    input  disp_rdata, disp_ack,
    output rend_req, rend_we, rend_addr, rend_wdata, rend_be,
    input  rend_rdata, rend_ack,
    input  sram_addr, sram_dout, sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
    output sram_din,
    input  busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Display-priority arbiter and fixed-timing sequencer for the shared video SRAM.
// Optional renderer starvation guard: define SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave arb
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD  = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] cnt;
  logic       win_rend;
  logic       is_wr;
  logic       guard_fire;
  logic       rend_win;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  logic [3:0] gcnt;

  assign guard_fire = arb.rend_req && (gcnt == STARVE_LIM);

  // Counts display grants made over a waiting renderer; cleared once it is served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt <= 4'd0;
    end else if (state == IDLE) begin
      if (!arb.rend_req)
        gcnt <= 4'd0;
      else if (rend_win)
        gcnt <= 4'd0;
      else
        gcnt <= gcnt + 4'd1;
    end
  end
`else
  assign guard_fire = 1'b0;
`endif

  assign rend_win = arb.rend_req && (!arb.disp_req || guard_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      win_rend         <= 1'b0;
      is_wr            <= 1'b0;
      arb.sram_addr    <= 20'd0;
      arb.sram_dout    <= 32'd0;
      arb.sram_dout_en <= 1'b0;
      arb.sram_ce_n    <= 1'b1;
      arb.sram_oe_n    <= 1'b1;
      arb.sram_we_n    <= 1'b1;
      arb.sram_be_n    <= 4'hF;
      arb.disp_rdata   <= 32'd0;
      arb.disp_ack     <= 1'b0;
      arb.rend_rdata   <= 32'd0;
      arb.rend_ack     <= 1'b0;
      arb.busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb.disp_req || arb.rend_req) begin
            state         <= ACCESS;
            cnt           <= CNT_LOAD;
            arb.busy      <= 1'b1;
            arb.sram_ce_n <= 1'b0;
            win_rend      <= rend_win;
            if (rend_win) begin
              arb.sram_addr <= arb.rend_addr;
              is_wr         <= arb.rend_we;
              if (arb.rend_we) begin
                arb.sram_dout    <= arb.rend_wdata;
                arb.sram_dout_en <= 1'b1;
                arb.sram_we_n    <= 1'b0;
                arb.sram_be_n    <= ~arb.rend_be;
              end else begin
                arb.sram_oe_n <= 1'b0;
                arb.sram_be_n <= 4'h0;
              end
            end else begin
              arb.sram_addr <= arb.disp_addr;
              is_wr         <= 1'b0;
              arb.sram_oe_n <= 1'b0;
              arb.sram_be_n <= 4'h0;
            end
          end
        end

        ACCESS: begin
          if (cnt == 4'd0) begin
            state            <= DONE;
            arb.sram_ce_n    <= 1'b1;
            arb.sram_oe_n    <= 1'b1;
            arb.sram_we_n    <= 1'b1;
            arb.sram_be_n    <= 4'hF;
            arb.sram_dout_en <= 1'b0;
            if (win_rend) begin
              arb.rend_ack <= 1'b1;
              if (!is_wr)
                arb.rend_rdata <= arb.sram_din;
            end else begin
              arb.disp_ack   <= 1'b1;
              arb.disp_rdata <= arb.sram_din;
            end
          end else begin
            cnt <= cnt - 4'd1;
            // Release we_n one cycle early so data is held past the write strobe.
            if (is_wr && cnt == 4'd1)
              arb.sram_we_n <= 1'b1;
          end
        end

        DONE: begin
          state        <= IDLE;
          arb.disp_ack <= 1'b0;
          arb.rend_ack <= 1'b0;
          arb.busy     <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
